// File: rtl/mem_stage.sv
// mem_stage: EX->WB memory stage; waits on data_ok, aligns loads, drains after flush.
// Optional MEM_BYPASS_EN: drive ms_bypass and stall ID only while a load is outstanding.
module mem_stage #(
  parameter int DATA_W    = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          left_valid,
  output logic                          left_ready,
  output logic                          right_valid,
  input  logic                          right_ready,
  input  logic [DATA_W-1:0]             ex_pc,
  input  logic [DATA_W-1:0]             ex_inst,
  input  logic [DATA_W-1:0]             ex_result,
  input  logic                          ex_wreg_en,
  input  logic [REG_IDX_W-1:0]          ex_wreg_index,
  input  logic                          ex_is_load,
  input  logic [2:0]                    ex_load_op,
  input  logic                          ex_excp,
  input  logic                          data_ok,
  input  logic [DATA_W-1:0]             data_rdata,
  output logic [DATA_W-1:0]             ms_pc,
  output logic [DATA_W-1:0]             ms_inst,
  output logic [DATA_W-1:0]             ms_result,
  output logic                          ms_wreg_en,
  output logic [REG_IDX_W-1:0]          ms_wreg_index,
  output logic                          ms_excp,
  output logic [1+REG_IDX_W+DATA_W-1:0] ms_bypass,
  output logic                          ms_load_stall
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0]    pc_q;
  logic [DATA_W-1:0]    inst_q;
  logic [DATA_W-1:0]    result_q, result_d;
  logic                 wen_q;
  logic [REG_IDX_W-1:0] widx_q;
  logic                 excp_q;
  logic [2:0]           op_q;

  logic accept;
  logic start_load;
  logic load_done;
  logic [DATA_W-1:0] aligned;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  assign accept     = left_valid & left_ready & ~flush;
  assign start_load = ex_is_load & ~ex_excp;
  assign load_done  = (state_q == S_WAIT) & data_ok & ~flush;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = start_load ? S_WAIT : S_READY;
      end
      S_WAIT: begin
        if (flush)        state_d = data_ok ? S_IDLE : S_DRAIN;
        else if (data_ok) state_d = S_READY;
      end
      S_READY: begin
        if (flush)            state_d = S_IDLE;
        else if (accept)      state_d = start_load ? S_WAIT : S_READY;
        else if (right_ready) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    left_ready  = 1'b0;
    right_valid = 1'b0;
    unique case (state_q)
      S_IDLE:  left_ready = 1'b1;
      S_READY: begin
        left_ready  = right_ready;
        right_valid = 1'b1;
      end
      default: begin
        left_ready  = 1'b0;
        right_valid = 1'b0;
      end
    endcase
  end

  // result_q still holds the effective address while the load is outstanding
  assign byte_v = data_rdata[{result_q[1:0], 3'b000} +: 8];
  assign half_v = data_rdata[{result_q[1], 4'b0000} +: 16];

  always_comb begin
    aligned = data_rdata;
    unique case (1'b1)
      (op_q == 3'b001): aligned = {{(DATA_W-8){byte_v[7]}}, byte_v};
      (op_q == 3'b010): aligned = {{(DATA_W-16){half_v[15]}}, half_v};
      (op_q == 3'b011): aligned = {{(DATA_W-8){1'b0}}, byte_v};
      (op_q == 3'b100): aligned = {{(DATA_W-16){1'b0}}, half_v};
      default:          aligned = data_rdata;
    endcase
  end

  always_comb begin
    result_d = result_q;
    if (accept)         result_d = ex_result;
    else if (load_done) result_d = aligned;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= '0;
      inst_q   <= '0;
      result_q <= '0;
      wen_q    <= 1'b0;
      widx_q   <= '0;
      excp_q   <= 1'b0;
      op_q     <= 3'b000;
    end else begin
      result_q <= result_d;
      if (accept) begin
        pc_q   <= ex_pc;
        inst_q <= ex_inst;
        wen_q  <= ex_wreg_en;
        widx_q <= ex_wreg_index;
        excp_q <= ex_excp;
        op_q   <= ex_load_op;
      end
    end
  end

  assign ms_pc         = pc_q;
  assign ms_inst       = inst_q;
  assign ms_result     = result_q;
  assign ms_wreg_en    = wen_q;
  assign ms_wreg_index = widx_q;
  assign ms_excp       = excp_q;

`ifdef MEM_BYPASS_EN
  assign ms_bypass     = {wen_q & (state_q == S_READY), widx_q, result_q};
  assign ms_load_stall = (state_q == S_WAIT);
`else
  // without forwarding ID must stall on any dependency held here
  assign ms_bypass     = '0;
  assign ms_load_stall = (state_q != S_IDLE);
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed test-plan steps, then random traffic vs a transaction model.
module tb_mem_stage;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int BW = 1 + RW + DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush, left_valid, left_ready, right_valid, right_ready;
  logic [DW-1:0] ex_pc, ex_inst, ex_result;
  logic          ex_wreg_en;
  logic [RW-1:0] ex_wreg_index;
  logic          ex_is_load;
  logic [2:0]    ex_load_op;
  logic          ex_excp, data_ok;
  logic [DW-1:0] data_rdata;
  logic [DW-1:0] ms_pc, ms_inst, ms_result;
  logic          ms_wreg_en;
  logic [RW-1:0] ms_wreg_index;
  logic          ms_excp;
  logic [BW-1:0] ms_bypass;
  logic          ms_load_stall;

  int checks   = 0;
  int failures = 0;

  mem_stage #(.DATA_W(DW), .REG_IDX_W(RW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .left_valid(left_valid), .left_ready(left_ready),
    .right_valid(right_valid), .right_ready(right_ready),
    .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_result(ex_result),
    .ex_wreg_en(ex_wreg_en), .ex_wreg_index(ex_wreg_index),
    .ex_is_load(ex_is_load), .ex_load_op(ex_load_op), .ex_excp(ex_excp),
    .data_ok(data_ok), .data_rdata(data_rdata),
    .ms_pc(ms_pc), .ms_inst(ms_inst), .ms_result(ms_result),
    .ms_wreg_en(ms_wreg_en), .ms_wreg_index(ms_wreg_index),
    .ms_excp(ms_excp), .ms_bypass(ms_bypass), .ms_load_stall(ms_load_stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // load result from the ISA rules: pick the lane, then extend
  function automatic logic [31:0] ref_load(input logic [2:0] op,
                                           input logic [31:0] addr,
                                           input logic [31:0] rd);
    int unsigned off, b, h;
    logic [31:0] r;
    off = addr % 4;
    b = (rd >> (8 * off)) & 32'hFF;
    h = (rd >> (16 * (off / 2))) & 32'hFFFF;
    case (op)
      3'd1: r = (b >= 128) ? b - 32'd256 : b;
      3'd2: r = (h >= 32768) ? h - 32'd65536 : h;
      3'd3: r = b;
      3'd4: r = h;
      default: r = rd;
    endcase
    return r;
  endfunction

  task automatic do_load(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] rd, input int dly);
    left_valid = 1; ex_is_load = 1; ex_load_op = op;
    ex_result = addr; ex_excp = 0;
    tick;
    left_valid = 0; ex_is_load = 0;
    repeat (dly) tick;
    data_ok = 1; data_rdata = rd;
    tick;
    data_ok = 0;
  endtask

  bit          full, waiting;
  logic [31:0] e_pc, e_res, e_addr;
  logic [2:0]  e_op;
  bit          e_excp, exp_lr;
  int          dly;

  initial begin
    reset = 1; flush = 0; left_valid = 0; right_ready = 1;
    ex_pc = 0; ex_inst = 0; ex_result = 0; ex_wreg_en = 0;
    ex_wreg_index = 0; ex_is_load = 0; ex_load_op = 0; ex_excp = 0;
    data_ok = 0; data_rdata = 0;
    tick; tick;
    chk("rst_rv", right_valid, 0);
    chk("rst_lr", left_ready, 1);
    chk("rst_stall", ms_load_stall, 0);
    chk("rst_result", ms_result, 0);
    chk("rst_pc", ms_pc, 0);
    chk("rst_bypass", ms_bypass, 0);
    chk("rst_wen", ms_wreg_en, 0);
    reset = 0;

    // add 0x1234 then a back-to-back add
    left_valid = 1; ex_pc = 32'h100; ex_result = 32'h1234;
    ex_wreg_en = 1; ex_wreg_index = 5'd5;
    #1 chk("add_lr", left_ready, 1);
    tick;
    chk("add_rv", right_valid, 1);
    chk("add_res", ms_result, 32'h1234);
    chk("add_pc", ms_pc, 32'h100);
`ifdef MEM_BYPASS_EN
    chk("add_byp", ms_bypass, {1'b1, 5'd5, 32'h1234});
`else
    chk("add_byp", ms_bypass, 0);
`endif
    ex_pc = 32'h104; ex_result = 32'h5678;
    #1 chk("b2b_lr", left_ready, 1);
    tick;
    chk("b2b_rv", right_valid, 1);
    chk("b2b_res", ms_result, 32'h5678);
    left_valid = 0;
    tick;
    chk("drain_rv", right_valid, 0);

    // ld.b at offset 3, data_ok in the third wait cycle
    left_valid = 1; ex_is_load = 1; ex_load_op = 3'd1; ex_result = 32'h1003;
    tick;
    left_valid = 0; ex_is_load = 0;
    for (int i = 0; i < 3; i++) begin
      chk("ldb_stall", ms_load_stall, 1);
      chk("ldb_rv0", right_valid, 0);
      chk("ldb_lr0", left_ready, 0);
      if (i == 2) begin data_ok = 1; data_rdata = 32'h80FF0000; end
      tick;
    end
    data_ok = 0;
    chk("ldb_rv", right_valid, 1);
    chk("ldb_res", ms_result, 32'hFFFFFF80);
`ifdef MEM_BYPASS_EN
    chk("ldb_stall_rdy", ms_load_stall, 0);
`else
    chk("ldb_stall_rdy", ms_load_stall, 1);
`endif
    do_load(3'd3, 32'h1003, 32'h80FF0000, 0);
    chk("ldbu_res", ms_result, 32'h00000080);
    do_load(3'd2, 32'h2002, 32'h7FFF1234, 1);
    chk("ldh_res", ms_result, 32'h00007FFF);
    do_load(3'd4, 32'h2000, 32'h0000ABCD, 2);
    chk("ldhu_res", ms_result, 32'h0000ABCD);
    chk("ldhu_rv", right_valid, 1);

    // flush in WAIT, stale data_ok two cycles later
    left_valid = 1; ex_is_load = 1; ex_load_op = 3'd0; ex_result = 32'h3000;
    tick;
    left_valid = 0; ex_is_load = 0; flush = 1;
    tick;
    flush = 0; left_valid = 1; ex_result = 32'h4444;
    #1 chk("drn_lr", left_ready, 0);
    chk("drn_rv", right_valid, 0);
    tick;
    left_valid = 0; data_ok = 1; data_rdata = 32'hDEADBEEF;
    #1 chk("drn_lr2", left_ready, 0);
    tick;
    data_ok = 0;
    chk("drn_idle_lr", left_ready, 1);
    chk("drn_idle_rv", right_valid, 0);
    checks++;
    assert (ms_result !== 32'hDEADBEEF) else begin
      failures++;
      $error("FAIL drn_stale observed=%0h expected=not deadbeef", ms_result);
    end

    // backpressure for four cycles
    right_ready = 0; left_valid = 1; ex_result = 32'hAAAA5555; ex_pc = 32'h200;
    tick;
    ex_result = 32'h33; ex_pc = 32'h204;
    for (int i = 0; i < 4; i++) begin
      #1 chk("bp_rv", right_valid, 1);
      chk("bp_res", ms_result, 32'hAAAA5555);
      chk("bp_pc", ms_pc, 32'h200);
      chk("bp_lr", left_ready, 0);
      tick;
    end
    right_ready = 1;
    #1 chk("bp_rel_lr", left_ready, 1);
    tick;
    left_valid = 0;
    chk("bp_next_res", ms_result, 32'h33);
    chk("bp_next_pc", ms_pc, 32'h204);
    tick;
    chk("bp_idle", right_valid, 0);

    // flush and data_ok together in WAIT go straight to IDLE
    do_load(3'd0, 32'h10, 32'h1, 0);
    tick;
    left_valid = 1; ex_is_load = 1; ex_result = 32'h20;
    tick;
    left_valid = 0; ex_is_load = 0; flush = 1; data_ok = 1;
    tick;
    flush = 0; data_ok = 0;
    chk("fl_ok_lr", left_ready, 1);
    chk("fl_ok_rv", right_valid, 0);

    // flush in READY drops content and the same-cycle accept
    left_valid = 1; ex_result = 32'h55;
    tick;
    flush = 1; ex_result = 32'h66;
    tick;
    flush = 0; left_valid = 0;
    chk("fl_rdy_rv", right_valid, 0);
    chk("fl_rdy_lr", left_ready, 1);

    // reset while WAIT, then a stray data_ok
    left_valid = 1; ex_is_load = 1; ex_pc = 32'h300; ex_result = 32'h40;
    tick;
    left_valid = 0; ex_is_load = 0; reset = 1; data_ok = 1;
    tick;
    reset = 0; data_ok = 0;
    chk("rw_rv", right_valid, 0);
    chk("rw_stall", ms_load_stall, 0);
    chk("rw_lr", left_ready, 1);
    chk("rw_res", ms_result, 0);
    chk("rw_pc", ms_pc, 0);
    chk("rw_byp", ms_bypass, 0);
    data_ok = 1; data_rdata = 32'h12345678;
    tick;
    data_ok = 0;
    chk("rw_stray_rv", right_valid, 0);
    chk("rw_stray_stall", ms_load_stall, 0);

    // random traffic against a transaction-level occupancy model
    full = 0; waiting = 0; dly = 0;
    e_pc = 0; e_res = 0; e_addr = 0; e_op = 0; e_excp = 0;
    for (int n = 0; n < 600; n++) begin
      right_ready = ($urandom % 4) != 0;
      left_valid = ($urandom % 3) != 0;
      ex_pc = $urandom; ex_inst = $urandom; ex_result = $urandom;
      ex_load_op = 3'($urandom_range(0, 4));
      if (ex_load_op == 3'd2 || ex_load_op == 3'd4) ex_result[0] = 1'b0;
      ex_is_load = $urandom % 2;
      ex_excp = ($urandom % 8) == 0;
      data_rdata = $urandom;
      data_ok = waiting && dly == 0;
      if (waiting && dly > 0) dly--;
      #1;
      chk("rnd_rv", right_valid, full && !waiting);
      if (full && !waiting) begin
        chk("rnd_res", ms_result, e_res);
        chk("rnd_pc", ms_pc, e_pc);
        chk("rnd_excp", ms_excp, e_excp);
      end
      exp_lr = !full || (!waiting && right_ready);
      chk("rnd_lr", left_ready, exp_lr);
`ifdef MEM_BYPASS_EN
      chk("rnd_stall", ms_load_stall, waiting);
`else
      chk("rnd_stall", ms_load_stall, full);
`endif
      if (full && !waiting && right_ready) full = 0;
      if (waiting && data_ok) begin
        waiting = 0;
        e_res = ref_load(e_op, e_addr, data_rdata);
      end
      if (left_valid && exp_lr) begin
        full = 1;
        e_pc = ex_pc; e_op = ex_load_op; e_addr = ex_result;
        e_excp = ex_excp; e_res = ex_result;
        waiting = ex_is_load && !ex_excp;
        dly = $urandom_range(0, 3);
      end
      tick;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between EX and WB. It latches the EX result, and for loads waits for the data-cache `data_ok` response. It then aligns and sign/zero-extends the returned word and presents the result to WB over the valid/ready handshake. It also drains outstanding cache responses after an exception or ertn flush, so a stale response is never delivered to a later instruction.

## Interface
Parameters:
- `DATA_W`, 32, datapath and address width.
- `REG_IDX_W`, 5, register index width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `flush` in 1: excp_flush | ertn_flush from WB. Kills the stage content this cycle.
- `left_valid` in 1: EX holds a valid instruction.
- `left_ready` out 1: stage accepts from EX this cycle.
- `right_valid` out 1: result is valid toward WB.
- `right_ready` in 1: WB accepts.
- `ex_pc` in 32: instruction PC.
- `ex_inst` in 32: instruction word.
- `ex_result` in 32: ALU result; equals the effective address for memory ops.
- `ex_wreg_en` in 1: GPR write enable.
- `ex_wreg_index` in REG_IDX_W: destination register.
- `ex_is_load` in 1: instruction is a load and a cache request was issued in EX.
- `ex_load_op` in 3: load width/sign code. 000 ld.w, 001 ld.b, 010 ld.h, 011 ld.bu, 100 ld.hu.
- `ex_excp` in 1: instruction carries an exception. If set, the cache request was suppressed.
- `data_ok` in 1: cache response valid, one pulse per request.
- `data_rdata` in 32: cache read data.
- `ms_pc`, `ms_inst`, `ms_result` out 32: registered or aligned outputs to WB.
- `ms_wreg_en` out 1, `ms_wreg_index` out REG_IDX_W, `ms_excp` out 1.
- `ms_bypass` out 1+REG_IDX_W+32: {wreg_en & valid & !waiting, wreg_index, result} for ID forwarding.
- `ms_load_stall` out 1: a load is in this stage and its data is not yet back. ID stalls on a register match.

## Operation
FSM states: IDLE (empty), WAIT (load outstanding), READY (result held), DRAIN (flushed load outstanding).
- Accept condition: `left_valid & left_ready`. `left_ready = (state==IDLE) | (state==READY & right_ready)`. `left_ready` is 0 in WAIT and DRAIN.
- On accept, capture all ex_* fields:
  - ex_is_load & !ex_excp → WAIT.
  - Otherwise → READY, with ms_result = ex_result.
- WAIT & data_ok: align data_rdata into ms_result → READY.
- Alignment:
  - The byte offset is `ex_result[1:0]`.
  - ld.b/bu select byte [8*off+7:8*off].
  - ld.h/hu select halfword at off[1]. off[0] is ignored because ALE was already raised in EX.
  - Sign-extend for .b/.h; zero-extend for .bu/.hu. ld.w passes the full word.
- READY & right_ready & no accept → IDLE.
- READY & right_ready & accept → new content, following the rules above.
- `right_valid = (state==READY)`.
- Flush:
  - In WAIT, a flush → DRAIN, unless data_ok arrives the same cycle, in which case → IDLE.
  - From IDLE or READY, a flush → IDLE.
  - An accept in the flush cycle is ignored.
- DRAIN & data_ok → IDLE; the data is discarded. A flush while in DRAIN stays in DRAIN.
- `ms_load_stall = (state==WAIT)`.

## Timing
- Reset:
  - state=IDLE; right_valid=0; left_ready=1; ms_load_stall=0.
  - All ms_* data outputs are 0; ms_bypass is 0.
  - Reset overrides flush and data_ok, including in WAIT and DRAIN. The external cache is reset in the same cycle.
- Non-load latency: accepted in cycle N, right_valid in N+1.
- Load latency: right_valid in the cycle after data_ok is sampled. data_ok is never sampled in the accept cycle.
- Back-to-back throughput for non-loads is 1 per cycle while right_ready=1.
- Outputs are stable while right_valid=1 & right_ready=0.

## Configuration
- `MEM_BYPASS_EN` defined:
  - ms_bypass is driven as above.
  - In READY, a load result is forwarded in the same cycle it becomes valid.
- Undefined:
  - ms_bypass is tied to 0.
  - ID must stall on any register dependency on this stage; ms_load_stall then asserts whenever state!=IDLE.

## Test plan
- add result 0x1234, right_ready=1 → right_valid one cycle after accept; ms_result=0x1234; next instruction accepted back-to-back.
- ld.b, addr 0x...03, rdata 0x80FF0000, data_ok 3 cycles after accept → ms_result=0xFFFFFF80, ms_load_stall=1 for 3 cycles; ld.bu on same → 0x00000080.
- ld.h, addr offset 2, rdata 0x7FFF1234 → 0x00007FFF; ld.hu, offset 0, rdata 0x0000ABCD → 0x0000ABCD.
- flush in WAIT, data_ok 2 cycles later with 0xDEADBEEF → DRAIN, left_ready=0 until data_ok, then IDLE; no right_valid, 0xDEADBEEF never appears on ms_result.
- right_ready=0 for 4 cycles with result held → outputs constant, left_ready=0; release → IDLE or accept the next instruction in the same cycle.
- reset asserted in WAIT → IDLE the next cycle, all outputs 0; a subsequent data_ok pulse is ignored.
